// File: rtl/regfile_dump_engine.sv
// Register-file dump engine: walks FIRST_ADDR..LAST_ADDR through one read port and streams {addr, data} words.
// Optional trailing XOR checksum word when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_engine #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef REGDUMP_CHECKSUM_EN
    localparam logic [2:0] S_CSUM = 3'd3;
`endif

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [DATA_W-1:0] odata_q, odata_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        last_d   = last_q;
        oaddr_d  = oaddr_q;
        odata_d  = odata_q;
        rf_raddr = '0;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = FIRST_A;
                    state_d = S_READ;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_READ: begin
                // rf_rdata is only captured here; later regfile writes cannot disturb the held word
                rf_raddr = addr_q;
                odata_d  = rf_rdata;
                oaddr_d  = addr_q;
                valid_d  = 1'b1;
                state_d  = S_SEND;
`ifdef REGDUMP_CHECKSUM_EN
                last_d   = 1'b0;
                csum_d   = csum_q ^ rf_rdata;
`else
                last_d   = (addr_q == LAST_A);
`endif
            end
            S_SEND: begin
                if (out_ready) begin
                    if (addr_q == LAST_A) begin
`ifdef REGDUMP_CHECKSUM_EN
                        valid_d = 1'b1;
                        oaddr_d = '1;
                        odata_d = csum_q;
                        last_d  = 1'b1;
                        state_d = S_CSUM;
`else
                        valid_d = 1'b0;
                        state_d = S_DONE;
`endif
                    end else begin
                        valid_d = 1'b0;
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_READ;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= FIRST_A;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign out_valid = valid_q;
    assign out_addr  = oaddr_q;
    assign out_data  = odata_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Bench for regfile_dump_engine: queue-based reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_regfile_dump_engine;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
    localparam int DUMP_LAT = 66;
`else
    localparam bit CSUM = 1'b0;
    localparam int DUMP_LAT = 65;
`endif

    logic clk;
    logic rst, start, out_ready;
    logic busy, done, out_valid, out_last;
    logic [AW-1:0] rf_raddr, out_addr;
    logic [DW-1:0] rf_rdata, out_data;

    logic start1, out_ready1;
    logic busy1, done1, out_valid1, out_last1;
    logic [AW-1:0] rf_raddr1, out_addr1;
    logic [DW-1:0] rf_rdata1, out_data1;

    logic [DW-1:0] regs [32];
    assign rf_rdata  = regs[rf_raddr];
    assign rf_rdata1 = regs[rf_raddr1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_dump_engine dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
    );

    regfile_dump_engine #(.FIRST_ADDR(5), .LAST_ADDR(5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rf_raddr(rf_raddr1), .rf_rdata(rf_rdata1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_addr(out_addr1), .out_data(out_data1), .out_last(out_last1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a dump is the ordered list of words snapshotted at start; one idle cycle
    // precedes each data word, the checksum word follows its predecessor directly.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
        logic          c;
    } word_t;

    word_t q[$];
    bit exp_busy = 0, exp_done = 0, exp_valid = 0;

    always @(negedge clk) begin
        logic [DW-1:0] x;
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        check("out_valid", out_valid, exp_valid);
        if (!exp_busy) check("rf_raddr_idle", rf_raddr, 0);
        if (exp_valid && q.size() > 0) begin
            check("out_addr", out_addr, q[0].a);
            check("out_data", out_data, q[0].d);
            check("out_last", out_last, q[0].l);
        end
        if (rst) begin
            q.delete();
            exp_busy = 0; exp_done = 0; exp_valid = 0;
        end else if (exp_done) begin
            exp_done = 0;
        end else if (!exp_busy) begin
            if (start) begin
                x = '0;
                for (int unsigned a = 0; a < 32; a++) begin
                    q.push_back('{a: AW'(a), d: regs[a], l: (a == 31) && !CSUM, c: 1'b0});
                    x ^= regs[a];
                end
                if (CSUM) q.push_back('{a: '1, d: x, l: 1'b1, c: 1'b1});
                exp_busy = 1; exp_valid = 0;
            end
        end else if (exp_valid) begin
            if (out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    exp_busy = 0; exp_valid = 0; exp_done = 1;
                end else begin
                    exp_valid = q[0].c;
                end
            end
        end else begin
            exp_valid = 1;
        end
    end

    logic [AW-1:0] got_a[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int first_k;

    task automatic dump_timed(input int restart_at, output int k);
        got_a.delete(); got_d.delete(); got_l.delete();
        first_k = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        while (!done && k < 300) begin
            if (out_valid && first_k < 0) first_k = k;
            if (out_valid && out_ready) begin
                got_a.push_back(out_addr); got_d.push_back(out_data); got_l.push_back(out_last);
            end
            start = (k == restart_at);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        check("done_timeout", k < 300, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", n < 400, 1);
    endtask

    task automatic wait_word(input logic [AW-1:0] a);
        int n = 0;
        while (!(out_valid && out_addr == a) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_word_timeout", n < 200, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nl;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; start1 = 1'b0; out_ready1 = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = DW'(i * 3);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_out_addr", out_addr, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rf_raddr", rf_raddr, 0);
        check("reset1_out_valid", out_valid1, 0);
        check("reset1_out_data", out_data1, 0);

        // Full dump, ready held high
        dump_timed(-1, k);
        check("t1_done_latency", k, DUMP_LAT);
        check("t1_first_valid", first_k, 2);
        check("t1_word_count", got_a.size(), CSUM ? 33 : 32);
        check("t1_addr0", got_a[0], 0);
        check("t1_data10", got_d[10], 30);
        check("t1_addr31", got_a[31], 31);
        check("t1_data31", got_d[31], 93);
        nl = 0;
        foreach (got_l[i]) if (got_l[i]) nl++;
        check("t1_last_count", nl, 1);
        check("t1_last_on_final", got_l[got_l.size()-1], 1);
        wait_idle();

        // Backpressure on word 4, with a regfile write while it is held
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_word(4);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("t2_hold_addr", out_addr, 4);
            check("t2_hold_data", out_data, 12);
            check("t2_hold_valid", out_valid, 1);
            if (c == 0) regs[4] = 32'hFFFF_FFFF;
            @(posedge clk); #1;
        end
        check("t2_held_after_write", out_data, 12);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t2_gap_valid", out_valid, 0);
        @(posedge clk); #1;
        check("t2_next_addr", out_addr, 5);
        check("t2_next_data", out_data, 15);
        wait_idle();
        regs[4] = 32'd12;

        // Restart attempt mid-dump
        dump_timed(10, k);
        check("t3_done_latency", k, DUMP_LAT);
        check("t3_word_count", got_a.size(), CSUM ? 33 : 32);
        check("t3_data31", got_d[31], 93);
        wait_idle();

        // Reset mid-dump
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_word(7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_valid_after_rst", out_valid, 0);
        check("t4_busy_after_rst", busy, 0);
        check("t4_addr_after_rst", out_addr, 0);
        nl = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) nl++;
        end
        check("t4_no_done", nl, 0);
        dump_timed(-1, k);
        check("t4_restart_addr0", got_a[0], 0);
        check("t4_restart_latency", k, DUMP_LAT);
        wait_idle();

        // Single-address instance
        regs[5] = 32'hDEAD_BEEF;
        got_a.delete(); got_d.delete(); got_l.delete();
        start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
        k = 1;
        while (!done1 && k < 20) begin
            if (out_valid1) begin
                got_a.push_back(out_addr1); got_d.push_back(out_data1); got_l.push_back(out_last1);
            end
            @(posedge clk); #1;
            k++;
        end
        check("t5_done_latency", k, CSUM ? 4 : 3);
        check("t5_word_count", got_a.size(), CSUM ? 2 : 1);
        check("t5_addr", got_a[0], 5);
        check("t5_data", got_d[0], 32'hDEAD_BEEF);
        check("t5_last", got_l[0], !CSUM);
        if (CSUM) begin
            check("t5_csum_addr", got_a[1], 5'h1F);
            check("t5_csum_data", got_d[1], 32'hDEAD_BEEF);
        end
        regs[5] = 32'd15;

`ifdef REGDUMP_CHECKSUM_EN
        for (int i = 0; i < 32; i++) regs[i] = DW'(i);
        dump_timed(-1, k);
        check("t6_csum_addr", got_a[32], 5'h1F);
        check("t6_csum_data", got_d[32], 0);
        check("t6_csum_last", got_l[32], 1);
        check("t6_data_last_low", got_l[31], 0);
        wait_idle();
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1] = 32'hA5;
        dump_timed(-1, k);
        check("t6_csum_a5", got_d[32], 32'hA5);
        wait_idle();
`endif

        // Randomized traffic: random ready, start, rare reset, regfile reloads only while idle
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 99) < 65);
            if (!busy && !done && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 32; i++) regs[i] = $urandom;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; out_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
